// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the request opcode encodings, the iteration count and the FSM state codes.
package mult_div_unit_pkg;

  // Request opcodes; 6 and 7 are accepted as no-ops.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // One radix-2 step per cycle over a 32-bit operand.
  localparam logic [5:0] MDU_ITERS = 6'd32;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

endpackage

// File: rtl/mdu_signfix.sv
// Signed-magnitude conditioning for the multiply/divide unit.
// Used both to take operand magnitudes (neg_i = operand sign) and to apply
// the result sign (neg_i = result must be negative).
//   value_i  : input value
//   neg_i    : 1 = two's-complement negate, 0 = pass through
//   result_o : conditioned value
module mdu_signfix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] value_i,
  input  logic             neg_i,
  output logic [Width-1:0] result_o
);

  assign result_o = neg_i ? ('0 - value_i) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, one step per
// cycle for 32 cycles, followed by one sign-fixup cycle that writes HI/LO.
//   clock, reset      : clock and synchronous active-high reset
//   req_valid/op/a/b  : issue strobe, opcode and operands (sampled when busy=0)
//   busy              : arithmetic operation in flight
//   done              : one-cycle pulse when hi/lo carry a new arithmetic result
//   hi, lo            : architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;   // negate product / quotient
  logic        neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic        div_zero_q, div_zero_d;
  logic [31:0] a_raw_q, a_raw_d;       // raw dividend, returned as HI on divide-by-zero
  logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [31:0] acc_hi_q, acc_hi_d;     // partial product high / partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend-quotient bits
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand conditioning
  logic        op_signed, op_mult, op_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign op_signed = (req_op == MDU_MULT) || (req_op == MDU_DIV);
  assign op_mult   = (req_op == MDU_MULT) || (req_op == MDU_MULTU);
  assign op_div    = (req_op == MDU_DIV)  || (req_op == MDU_DIVU);
  assign a_neg     = op_signed & req_a[31];
  assign b_neg     = op_signed & req_b[31];

  mdu_signfix #(.Width(32)) u_abs_a (
    .value_i  (req_a),
    .neg_i    (a_neg),
    .result_o (a_mag)
  );

  mdu_signfix #(.Width(32)) u_abs_b (
    .value_i  (req_b),
    .neg_i    (b_neg),
    .result_o (b_mag)
  );

  // Result conditioning
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  mdu_signfix #(.Width(64)) u_fix_prod (
    .value_i  ({acc_hi_q, acc_lo_q}),
    .neg_i    (neg_res_q),
    .result_o (prod_fix)
  );

  mdu_signfix #(.Width(32)) u_fix_quot (
    .value_i  (acc_lo_q),
    .neg_i    (neg_res_q),
    .result_o (quot_fix)
  );

  mdu_signfix #(.Width(32)) u_fix_rem (
    .value_i  (acc_hi_q),
    .neg_i    (neg_rem_q),
    .result_o (rem_fix)
  );

  // Datapath step terms
  logic [32:0] add_sum;    // multiply: partial product plus optional multiplicand
  logic [32:0] rem_shift;  // divide: remainder shifted left with next dividend bit
  logic [32:0] rem_diff;   // divide: trial subtraction, bit 32 set when it underflows

  assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign rem_shift = {acc_hi_q, acc_lo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_raw_d    = a_raw_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == MDU_MTHI) begin
            hi_d = req_a;
          end else if (req_op == MDU_MTLO) begin
            lo_d = req_a;
          end else if (op_mult || op_div) begin
            state_d    = StRun;
            cnt_d      = MDU_ITERS;
            is_div_d   = op_div;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            div_zero_d = op_div && (req_b == 32'd0);
            a_raw_d    = req_a;
            acc_hi_d   = 32'd0;
            // Multiply: acc_lo holds the multiplier, opnd the multiplicand.
            // Divide:   acc_lo holds the dividend,   opnd the divisor.
            acc_lo_d   = op_mult ? b_mag : a_mag;
            opnd_d     = op_mult ? a_mag : b_mag;
          end
        end
      end

      StRun: begin
        if (is_div_q) begin
          if (!rem_diff[32]) begin
            acc_hi_d = rem_diff[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = rem_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[31:1]};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div_zero_q) begin
          hi_d = a_raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= 32'd0;
      opnd_q     <= 32'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_raw_q    <= a_raw_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// arithmetic compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  // Expected architectural HI/LO
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OpMult:  return 64'(sa * sb);
      OpMultu: return ua * ub;
      OpDiv: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OpDivu: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Called at a negedge; issues on the next posedge and returns at the
  // negedge of the done cycle.
  task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit poke);
    logic [63:0] exp;
    exp       = model(op, a, b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clock);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    for (int i = 0; i < 33; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
      if (poke && i == 10) begin
        req_valid = 1'b1;
        req_op    = OpMtlo;
        req_a     = 32'h8765_4321;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("hi_result", hi, exp[63:32]);
    chk("lo_result", lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic idle_after;
    @(negedge clock);
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = $urandom;
    @(negedge clock);
    req_valid = 1'b0;
    if (op == OpMthi) m_hi = a;
    if (op == OpMtlo) m_lo = a;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_done", 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    checks    = 0;
    failures  = 0;
    clock     = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Directed corner cases
    run_arith(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", lo, 32'h0000_0001);
    idle_after();
    run_arith(OpMult, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFEB);
    idle_after();
    run_arith(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    idle_after();
    run_arith(OpDivu, 32'd100, 32'd0, 1'b0);
    chk("divu0_hi_const", hi, 32'd100);
    chk("divu0_lo_const", lo, 32'hFFFF_FFFF);
    idle_after();
    run_arith(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_hi_const", hi, 32'd0);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    idle_after();
    run_arith(OpDiv, 32'hFFFF_FFF0, 32'd0, 1'b0);
    idle_after();

    // MTLO while busy is ignored (checked inside via lo_hold and lo_result)
    run_arith(OpMultu, 32'd5, 32'd7, 1'b1);
    idle_after();
    move_to(OpMtlo, 32'h8765_4321);
    move_to(OpMthi, 32'hCAFE_F00D);
    move_to(3'd6, 32'h1111_1111);
    move_to(3'd7, 32'h2222_2222);

    // Back-to-back issue in the done cycle
    run_arith(OpMult, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
    run_arith(OpMultu, 32'd2, 32'd3, 1'b0);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd6);
    idle_after();

    // Random arithmetic
    for (int n = 0; n < 16; n++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (n % 5 == 0) b = 32'd0;
      if (n % 7 == 3) b = $urandom_range(1, 15);
      if (n % 4 == 1) a = 32'($urandom_range(0, 1000));
      run_arith(op, a, b, 1'b0);
      idle_after();
    end

    // Reset 10 cycles into a MULTU, with a request on the reset edge
    move_to(OpMthi, 32'h5555_AAAA);
    req_valid = 1'b1;
    req_op    = OpMultu;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'hFFFF_FFFF;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = OpMthi;
    req_a     = 32'h1234_5678;
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("post_rst_hi", hi, m_hi);
    chk("post_rst_lo", lo, m_lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
